// File: rtl/layernorm_sequencer_if.sv
// Control bundle between the LayerNorm sequencer and its datapath stages.
// The sequencer uses the master modport. The datapath and the vector buffer use the slave modport.
interface layernorm_sequencer_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  start_in;
  logic                  busy_out;
  logic                  done_out;
  logic                  rd_en_out;
  logic [ADDR_WIDTH-1:0] rd_addr_out;
  logic                  mean_clr_out;
  logic                  var_clr_out;
  logic                  mean_acc_en_out;
  logic                  var_acc_en_out;
  logic                  norm_en_out;
  logic                  norm_last_out;
  logic                  mean_valid_in;
  logic                  variance_valid_in;
  logic                  var_plus_eps_valid_in;
  logic                  sqrt_valid_in;
  logic                  sqrt_start_out;
  logic                  timeout_err_out;

  modport master (
    input  start_in, mean_valid_in, variance_valid_in, var_plus_eps_valid_in, sqrt_valid_in,
    output busy_out, done_out, rd_en_out, rd_addr_out, mean_clr_out, var_clr_out,
           mean_acc_en_out, var_acc_en_out, norm_en_out, norm_last_out,
           sqrt_start_out, timeout_err_out
  );

  modport slave (
    output start_in, mean_valid_in, variance_valid_in, var_plus_eps_valid_in, sqrt_valid_in,
    input  busy_out, done_out, rd_en_out, rd_addr_out, mean_clr_out, var_clr_out,
           mean_acc_en_out, var_acc_en_out, norm_en_out, norm_last_out,
           sqrt_start_out, timeout_err_out
  );
endinterface

// File: rtl/layernorm_sequencer.sv
// Control FSM for one LayerNorm vector: mean pass, variance pass, eps/sqrt handoff, normalize pass.
// Define LN_SEQ_TIMEOUT_EN to add a wait-state watchdog that drives the sticky timeout_err_out flag.
module layernorm_sequencer #(
  parameter int VEC_LEN        = 64,
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  layernorm_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  if (VEC_LEN < 2 || (2 ** ADDR_WIDTH) < VEC_LEN || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("layernorm_sequencer: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    IDLE, MEAN_PASS, MEAN_WAIT, VAR_PASS, VAR_WAIT,
    EPS_WAIT, SQRT_GO, SQRT_WAIT, NORM_PASS, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  pass_nxt;
  logic                  wait_expired;
  logic                  busy, done, rd_en, mean_clr, var_clr;
  logic                  mean_acc_en, var_acc_en, norm_en, norm_last, sqrt_start;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Next-state logic; the element counter wraps to 0 at the end of each pass.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:      if (bus.start_in) state_nxt = MEAN_PASS;
      MEAN_PASS, VAR_PASS, NORM_PASS: begin
        if (cnt == LAST_IDX) begin
          cnt_nxt = '0;
          case (state)
            MEAN_PASS: state_nxt = MEAN_WAIT;
            VAR_PASS:  state_nxt = VAR_WAIT;
            default:   state_nxt = DONE;
          endcase
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      MEAN_WAIT: if (bus.mean_valid_in)         state_nxt = VAR_PASS;
                 else if (wait_expired)         state_nxt = IDLE;
      VAR_WAIT:  if (bus.variance_valid_in)     state_nxt = EPS_WAIT;
                 else if (wait_expired)         state_nxt = IDLE;
      EPS_WAIT:  if (bus.var_plus_eps_valid_in) state_nxt = SQRT_GO;
                 else if (wait_expired)         state_nxt = IDLE;
      SQRT_GO:   state_nxt = SQRT_WAIT;
      SQRT_WAIT: if (bus.sqrt_valid_in)         state_nxt = NORM_PASS;
                 else if (wait_expired)         state_nxt = IDLE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    pass_nxt = (state_nxt == MEAN_PASS) || (state_nxt == VAR_PASS) || (state_nxt == NORM_PASS);
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      mean_clr    <= 1'b0;
      var_clr     <= 1'b0;
      mean_acc_en <= 1'b0;
      var_acc_en  <= 1'b0;
      norm_en     <= 1'b0;
      norm_last   <= 1'b0;
      sqrt_start  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      rd_en       <= pass_nxt;
      rd_addr     <= pass_nxt ? ADDR_WIDTH'(cnt_nxt) : '0;
      mean_clr    <= (state == IDLE) && (state_nxt == MEAN_PASS);
      var_clr     <= (state == MEAN_WAIT) && (state_nxt == VAR_PASS);
      mean_acc_en <= (state == MEAN_PASS);
      var_acc_en  <= (state == VAR_PASS);
      norm_en     <= (state == NORM_PASS);
      norm_last   <= (state == NORM_PASS) && (cnt == LAST_IDX);
      sqrt_start  <= (state_nxt == SQRT_GO);
    end
  end

`ifdef LN_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_err;
  logic              in_wait;

  assign in_wait = (state == MEAN_WAIT) || (state == VAR_WAIT) ||
                   (state == EPS_WAIT)  || (state == SQRT_WAIT);
  assign wait_expired = (wait_cnt == WAIT_LIMIT);

  // Wait counter restarts on every state change; the only way from a wait state to IDLE is a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_nxt != state) wait_cnt <= '0;
      else if (in_wait)       wait_cnt <= wait_cnt + WAIT_W'(1);
      if (state == IDLE && bus.start_in)    timeout_err <= 1'b0;
      else if (in_wait && state_nxt == IDLE) timeout_err <= 1'b1;
    end
  end

  assign bus.timeout_err_out = timeout_err;
`else
  assign wait_expired        = 1'b0;
  assign bus.timeout_err_out = 1'b0;
`endif

  assign bus.busy_out        = busy;
  assign bus.done_out        = done;
  assign bus.rd_en_out       = rd_en;
  assign bus.rd_addr_out     = rd_addr;
  assign bus.mean_clr_out    = mean_clr;
  assign bus.var_clr_out     = var_clr;
  assign bus.mean_acc_en_out = mean_acc_en;
  assign bus.var_acc_en_out  = var_acc_en;
  assign bus.norm_en_out     = norm_en;
  assign bus.norm_last_out   = norm_last;
  assign bus.sqrt_start_out  = sqrt_start;

endmodule
